// File: rtl/dot_matrix_scan_ctrl_if.sv
// Host-side bus of the dot-matrix scanner: back-buffer writes, swap handshake and matrix drive.
// Scroll controls exist only when DOT_MATRIX_SCROLL_EN is defined.
interface dot_matrix_scan_ctrl_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int RW = $clog2(ROWS);

    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;
    logic            frame_start;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
`ifdef DOT_MATRIX_SCROLL_EN
    logic            scroll_en;
    logic            scroll_dir;

    modport master (output wr_en, wr_row, wr_data, swap_req, scroll_en, scroll_dir,
                    input  swap_ack, frame_start, row, col);
    modport slave  (input  wr_en, wr_row, wr_data, swap_req, scroll_en, scroll_dir,
                    output swap_ack, frame_start, row, col);
`else
    modport master (output wr_en, wr_row, wr_data, swap_req,
                    input  swap_ack, frame_start, row, col);
    modport slave  (input  wr_en, wr_row, wr_data, swap_req,
                    output swap_ack, frame_start, row, col);
`endif
endinterface

// File: rtl/dot_matrix_scan_ctrl.sv
// Double-buffered row-scanning LED matrix driver with frame-synchronous buffer swap and blanking.
// Define DOT_MATRIX_SCROLL_EN to add per-frame horizontal column rotation.
module dot_matrix_scan_ctrl #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dot_matrix_scan_ctrl_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int OW = $clog2(COLS);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic            front_sel_q, front_sel_d;
    logic            swap_pending_q, swap_pending_d;
    logic            started_q, started_d;
    logic            swapped_q, swapped_d;
    logic [COLS-1:0] mem_q [2][ROWS];
    logic [COLS-1:0] mem_d [2][ROWS];
    logic [ROWS-1:0] row_q, row_d;
    logic [COLS-1:0] col_q, col_d;
    logic            swap_ack_q, swap_ack_d;
    logic            frame_start_q, frame_start_d;
    logic [OW-1:0]   offset;

    logic            boundary;
    logic            do_swap;
    logic            at_frame_head;
    logic [COLS-1:0] front_row;
    logic [COLS-1:0] rot_row;
    int              j;

`ifdef DOT_MATRIX_SCROLL_EN
    logic [OW-1:0] offset_q, offset_d;

    always_comb begin
        offset_d = offset_q;
        if (boundary && bus.scroll_en) begin
            if (bus.scroll_dir)
                offset_d = (offset_q == '0) ? OW'(COLS - 1) : offset_q - 1'b1;
            else
                offset_d = (offset_q == OW'(COLS - 1)) ? '0 : offset_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) offset_q <= '0;
        else        offset_q <= offset_d;
    end

    assign offset = offset_q;
`else
    assign offset = '0;
`endif

    always_comb begin
        boundary       = (cnt_q == CW'(SCAN_DIV - 1)) && (row_idx_q == RW'(ROWS - 1));
        do_swap        = boundary && (swap_pending_q || bus.swap_req);
        at_frame_head  = (cnt_q == '0) && (row_idx_q == '0);

        cnt_d          = (cnt_q == CW'(SCAN_DIV - 1)) ? '0 : cnt_q + 1'b1;
        row_idx_d      = row_idx_q;
        if (cnt_q == CW'(SCAN_DIV - 1))
            row_idx_d = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + 1'b1;

        front_sel_d    = front_sel_q ^ do_swap;
        swap_pending_d = !do_swap && (swap_pending_q || bus.swap_req);
        swapped_d      = do_swap;
        started_d      = 1'b1;

        // The back buffer is chosen by the pre-swap select, so a boundary write lands in the new front
        mem_d = mem_q;
        if (bus.wr_en && (32'(bus.wr_row) < ROWS))
            mem_d[front_sel_q ? 0 : 1][bus.wr_row] = bus.wr_data;

        front_row = mem_q[front_sel_q ? 1 : 0][row_idx_q];
        rot_row   = '0;
        j         = 0;
        for (int i = 0; i < COLS; i++) begin
            j = i + int'(offset);
            if (j >= COLS) j = j - COLS;
            rot_row[j] = front_row[i];
        end

        row_d = '1;
        col_d = '0;
        if (32'(cnt_q) >= BLANK_CYC) begin
            for (int i = 0; i < ROWS; i++)
                row_d[i] = (32'(row_idx_q) != i);
            col_d = rot_row;
        end

        frame_start_d = at_frame_head && started_q;
        swap_ack_d    = at_frame_head && swapped_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            row_idx_q      <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            started_q      <= 1'b0;
            swapped_q      <= 1'b0;
            row_q          <= '1;
            col_q          <= '0;
            swap_ack_q     <= 1'b0;
            frame_start_q  <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    mem_q[b][r] <= '0;
        end else begin
            cnt_q          <= cnt_d;
            row_idx_q      <= row_idx_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            started_q      <= started_d;
            swapped_q      <= swapped_d;
            row_q          <= row_d;
            col_q          <= col_d;
            swap_ack_q     <= swap_ack_d;
            frame_start_q  <= frame_start_d;
            mem_q          <= mem_d;
        end
    end

    assign bus.row         = row_q;
    assign bus.col         = col_q;
    assign bus.swap_ack    = swap_ack_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Randomised scoreboard bench for dot_matrix_scan_ctrl; ROWS=6 so out-of-range row writes are reachable.
// Scroll stimulus and model follow DOT_MATRIX_SCROLL_EN.
module tb_dot_matrix_scan_ctrl;
    localparam int ROWS  = 6;
    localparam int COLS  = 8;
    localparam int SD    = 4;
    localparam int BLANK = 1;
    localparam int FRAME = SD * ROWS;
    localparam int RW    = $clog2(ROWS);

    typedef struct packed {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        logic            ack;
        logic            fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dot_matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    dot_matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .BLANK_CYC(BLANK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: time since reset release decides the scan position
    exp_t            q[$];
    logic [COLS-1:0] mb[2][ROWS];
    int              m_t = 0;
    int              m_front = 0;
    int              m_off = 0;
    bit              m_pend = 0;
    bit              m_swapped = 0;

    function automatic logic [COLS-1:0] rotl(input logic [COLS-1:0] d, input int off);
        logic [COLS-1:0] o;
        o = '0;
        for (int i = 0; i < COLS; i++) o[(i + off) % COLS] = d[i];
        return o;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   cnt, r;
        bit   bnd;
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < ROWS; i++) mb[b][i] = '0;
            m_t = 0; m_front = 0; m_off = 0; m_pend = 0; m_swapped = 0;
            e = '{row: '1, col: '0, ack: 1'b0, fs: 1'b0};
        end else begin
            cnt   = m_t % SD;
            r     = (m_t / SD) % ROWS;
            bnd   = (m_t % FRAME) == FRAME - 1;
            e.fs  = (m_t > 0) && (m_t % FRAME == 0);
            e.ack = e.fs && m_swapped;
            if (cnt < BLANK) begin
                e.row = '1;
                e.col = '0;
            end else begin
                e.row = ~(ROWS'(1) << r);
                e.col = rotl(mb[m_front][r], m_off);
            end
            if (bus.wr_en && int'(bus.wr_row) < ROWS)
                mb[1 - m_front][bus.wr_row] = bus.wr_data;
            if (bnd) begin
                m_swapped = m_pend || bus.swap_req;
                if (m_swapped) begin
                    m_front = 1 - m_front;
                    m_pend  = 0;
                end
`ifdef DOT_MATRIX_SCROLL_EN
                if (bus.scroll_en)
                    m_off = bus.scroll_dir ? (m_off + COLS - 1) % COLS : (m_off + 1) % COLS;
`endif
            end else begin
                m_pend = m_pend || bus.swap_req;
            end
            m_t++;
        end
        q.push_back(e);
    end

    task automatic checkOutput(input exp_t e);
        exp_t a;
        a = '{row: bus.row, col: bus.col, ack: bus.swap_ack, fs: bus.frame_start};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL scan_out t=%0t: row=%h col=%h ack=%b fs=%b, required row=%h col=%h ack=%b fs=%b",
                     $time, a.row, a.col, a.ack, a.fs, e.row, e.col, e.ack, e.fs);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) checkOutput(q.pop_front());
    end

    task automatic applyStimulus(input logic wen, input logic [RW-1:0] wrow,
                                 input logic [COLS-1:0] wd, input logic sreq);
        bus.wr_en    = wen;
        bus.wr_row   = wrow;
        bus.wr_data  = wd;
        bus.swap_req = sreq;
        @(negedge clk);
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitBoundary();
        int guard = 0;
        while ((m_t % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if ((m_t % FRAME) != FRAME - 1) begin
            errors++;
            $display("[TB] FAIL boundary_wait: phase=%0d, required %0d", m_t % FRAME, FRAME - 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time=%0t, required finish before limit", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.swap_req = 1'b0;
`ifdef DOT_MATRIX_SCROLL_EN
        bus.scroll_en = 1'b0; bus.scroll_dir = 1'b0;
`endif
        idle(3);
        rst_n = 1'b1;
        $display("[TB] idle scan with cleared buffers");
        idle(2 * FRAME);

        $display("[TB] fill back buffer with 81 and swap mid-frame");
        for (int i = 0; i < ROWS; i++) applyStimulus(1'b1, RW'(i), 8'h81, 1'b0);
        idle(3);
        applyStimulus(1'b0, '0, '0, 1'b1);
        idle(2 * FRAME);

        $display("[TB] two requests in one frame, then one more");
        applyStimulus(1'b0, '0, '0, 1'b1);
        idle(2);
        applyStimulus(1'b0, '0, '0, 1'b1);
        idle(FRAME + 3);
        applyStimulus(1'b0, '0, '0, 1'b1);
        idle(2 * FRAME);

        $display("[TB] write and swap on the boundary cycle");
        waitBoundary();
        applyStimulus(1'b1, RW'(3), 8'hA5, 1'b1);
        idle(FRAME + 2);

        $display("[TB] out-of-range writes, then reset with a swap pending");
        applyStimulus(1'b1, RW'(6), 8'hFF, 1'b0);
        applyStimulus(1'b1, RW'(7), 8'hFF, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        idle(FRAME + 5);
        applyStimulus(1'b0, '0, '0, 1'b1);
        idle(4);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2 * FRAME + 2);

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) begin
`ifdef DOT_MATRIX_SCROLL_EN
            bus.scroll_en  = ($urandom_range(0, 3) != 0);
            bus.scroll_dir = 1'($urandom_range(0, 1));
`endif
            applyStimulus(($urandom_range(0, 2) == 0), RW'($urandom_range(0, 7)),
                          COLS'($urandom), ($urandom_range(0, 39) == 0));
        end

`ifdef DOT_MATRIX_SCROLL_EN
        $display("[TB] scroll single lit column left then right");
        bus.scroll_en = 1'b0;
        waitBoundary();
        applyStimulus(1'b1, '0, 8'h01, 1'b1);
        for (int i = 1; i < ROWS; i++) applyStimulus(1'b1, RW'(i), '0, 1'b0);
        bus.scroll_en = 1'b1; bus.scroll_dir = 1'b0;
        idle(9 * FRAME);
        bus.scroll_dir = 1'b1;
        idle(9 * FRAME);
        bus.scroll_en = 1'b0;
`endif
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
